// File: rtl/fare_account_if.sv
// Gate/reader-side bus of the fare account responder: tap, debit request,
// account programming, top-up and the registered response back to the gate.
interface fare_account_if #(
    parameter int ID_W  = 3,
    parameter int BAL_W = 8
);
    logic             nfc;
    logic [ID_W-1:0]  card_id;
    logic             reduce_bal;
    logic             cfg_we;
    logic [ID_W-1:0]  cfg_id;
    logic             cfg_active;
    logic             cfg_monthly;
    logic [BAL_W-1:0] cfg_bal;
    logic             topup_valid;
    logic [ID_W-1:0]  topup_id;
    logic [BAL_W-1:0] topup_amt;
    logic             resp_valid;
    logic             card_active;
    logic             fund_enough;
    logic             monthly;
    logic [BAL_W-1:0] balance_out;
    logic             busy;
    logic             err;

    modport master (
        output nfc, card_id, reduce_bal,
        output cfg_we, cfg_id, cfg_active, cfg_monthly, cfg_bal,
        output topup_valid, topup_id, topup_amt,
        input  resp_valid, card_active, fund_enough, monthly, balance_out, busy, err
    );

    modport slave (
        input  nfc, card_id, reduce_bal,
        input  cfg_we, cfg_id, cfg_active, cfg_monthly, cfg_bal,
        input  topup_valid, topup_id, topup_amt,
        output resp_valid, card_active, fund_enough, monthly, balance_out, busy, err
    );
endinterface

// File: rtl/fare_account_responder.sv
// Account-side responder for the fare gate: looks up a tapped card in a small
// register table, holds the response for the gate and debits the fare on request.
module fare_account_responder #(
    parameter int N_CARDS     = 8,
    parameter int ID_W        = 3,
    parameter int BAL_W       = 8,
    parameter int FARE        = 3,
    parameter int HOLD_CYCLES = 10
) (
    input  logic          clk,
    input  logic          rst,
    fare_account_if.slave bus
);
    localparam int DEPTH = 1 << ID_W;
    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [ID_W:0]    N_CARDS_W = (ID_W + 1)'(N_CARDS);
    localparam logic [BAL_W+1:0] FARE_W    = (BAL_W + 2)'(FARE);
    localparam logic [BAL_W+1:0] BAL_MAX_W = {2'b00, {BAL_W{1'b1}}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_HOLD   = 2'd2,
        ST_DEBIT  = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic             nfc_prev_q, nfc_prev_d;
    logic [ID_W-1:0]  held_id_q, held_id_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             act_tbl_q [DEPTH];
    logic             act_tbl_d [DEPTH];
    logic             mon_tbl_q [DEPTH];
    logic             mon_tbl_d [DEPTH];
    logic [BAL_W-1:0] bal_tbl_q [DEPTH];
    logic [BAL_W-1:0] bal_tbl_d [DEPTH];

    logic             resp_valid_q, resp_valid_d;
    logic             card_active_q, card_active_d;
    logic             fund_enough_q, fund_enough_d;
    logic             monthly_q, monthly_d;
    logic [BAL_W-1:0] balance_out_q, balance_out_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;

    logic             tap_s;
    logic             accept_s;

    function automatic logic id_ok(input logic [ID_W-1:0] id);
        return ({1'b0, id} < N_CARDS_W);
    endfunction

    // Saturating add of a top-up with an optional fare debit, clamped to [0, max].
    function automatic logic [BAL_W-1:0] bal_update(input logic [BAL_W-1:0] bal,
                                                    input logic [BAL_W-1:0] add,
                                                    input logic             sub);
        logic [BAL_W+1:0] sum;
        sum = {2'b00, bal} + {2'b00, add};
        if (sub) begin
            sum = (sum < FARE_W) ? '0 : (sum - FARE_W);
        end else begin
            sum = sum;
        end
        return (sum > BAL_MAX_W) ? BAL_MAX_W[BAL_W-1:0] : sum[BAL_W-1:0];
    endfunction

    assign tap_s    = bus.nfc && !nfc_prev_q;
    assign accept_s = (state_q == ST_HOLD) && bus.reduce_bal && card_active_q && fund_enough_q;

    // State and control registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            nfc_prev_q <= 1'b0;
            held_id_q  <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            nfc_prev_q <= nfc_prev_d;
            held_id_q  <= held_id_d;
            cnt_q      <= cnt_d;
        end
    end

    // Next-state logic; reduce_bal wins over a timeout in the last hold cycle.
    always_comb begin
        state_d    = state_q;
        nfc_prev_d = bus.nfc;
        held_id_d  = held_id_q;
        cnt_d      = '0;
        case (state_q)
            ST_IDLE: begin
                if (tap_s) begin
                    state_d   = ST_LOOKUP;
                    held_id_d = bus.card_id;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOOKUP: state_d = ST_HOLD;
            ST_HOLD: begin
                if (bus.reduce_bal) begin
                    state_d = accept_s ? ST_DEBIT : ST_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DEBIT: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Account table update: programming beats top-up and debit to the same id.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            act_tbl_d[i] = act_tbl_q[i];
            mon_tbl_d[i] = mon_tbl_q[i];
            bal_tbl_d[i] = bal_tbl_q[i];
            if (bus.cfg_we && id_ok(bus.cfg_id) && (bus.cfg_id == ID_W'(i))) begin
                act_tbl_d[i] = bus.cfg_active;
                mon_tbl_d[i] = bus.cfg_monthly;
                bal_tbl_d[i] = bus.cfg_bal;
            end else begin
                bal_tbl_d[i] = bal_update(
                    bal_tbl_q[i],
                    (bus.topup_valid && id_ok(bus.topup_id) && (bus.topup_id == ID_W'(i)))
                        ? bus.topup_amt : '0,
                    accept_s && (held_id_q == ID_W'(i)) && act_tbl_q[i] && !mon_tbl_q[i]);
            end
        end
    end

    // Account table registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_tbl_q <= '{default: 1'b0};
            mon_tbl_q <= '{default: 1'b0};
            bal_tbl_q <= '{default: '0};
        end else begin
            act_tbl_q <= act_tbl_d;
            mon_tbl_q <= mon_tbl_d;
            bal_tbl_q <= bal_tbl_d;
        end
    end

    // Response outputs; balance_out keeps its last value when the response drops.
    always_comb begin
        resp_valid_d  = resp_valid_q;
        card_active_d = card_active_q;
        fund_enough_d = fund_enough_q;
        monthly_d     = monthly_q;
        balance_out_d = balance_out_q;
        busy_d        = (state_d != ST_IDLE);
        err_d         = 1'b0;
        case (state_q)
            ST_LOOKUP: begin
                resp_valid_d = 1'b1;
                if (id_ok(held_id_q)) begin
                    card_active_d = act_tbl_q[held_id_q];
                    monthly_d     = mon_tbl_q[held_id_q];
                    fund_enough_d = mon_tbl_q[held_id_q] ||
                                    ({2'b00, bal_tbl_q[held_id_q]} >= FARE_W);
                    balance_out_d = bal_tbl_q[held_id_q];
                end else begin
                    card_active_d = 1'b0;
                    monthly_d     = 1'b0;
                    fund_enough_d = 1'b0;
                    balance_out_d = '0;
                end
            end
            ST_HOLD: begin
                err_d = bus.reduce_bal && !accept_s;
                if (state_d == ST_IDLE) begin
                    resp_valid_d  = 1'b0;
                    card_active_d = 1'b0;
                    fund_enough_d = 1'b0;
                    monthly_d     = 1'b0;
                end else if (state_d == ST_DEBIT) begin
                    balance_out_d = bal_tbl_d[held_id_q];
                end else begin
                    balance_out_d = balance_out_q;
                end
            end
            default: begin
                resp_valid_d  = 1'b0;
                card_active_d = 1'b0;
                fund_enough_d = 1'b0;
                monthly_d     = 1'b0;
            end
        endcase
    end

    // Output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_valid_q  <= 1'b0;
            card_active_q <= 1'b0;
            fund_enough_q <= 1'b0;
            monthly_q     <= 1'b0;
            balance_out_q <= '0;
            busy_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            resp_valid_q  <= resp_valid_d;
            card_active_q <= card_active_d;
            fund_enough_q <= fund_enough_d;
            monthly_q     <= monthly_d;
            balance_out_q <= balance_out_d;
            busy_q        <= busy_d;
            err_q         <= err_d;
        end
    end

    assign bus.resp_valid  = resp_valid_q;
    assign bus.card_active = card_active_q;
    assign bus.fund_enough = fund_enough_q;
    assign bus.monthly     = monthly_q;
    assign bus.balance_out = balance_out_q;
    assign bus.busy        = busy_q;
    assign bus.err         = err_q;
endmodule

// File: tb/tb_fare_account_responder.sv
// Directed plus randomized bench for fare_account_responder, checked against a
// transaction-level account model (balances, flags) kept in plain arrays.
module tb_fare_account_responder;
    localparam int N_CARDS = 8;
    localparam int FARE    = 3;
    localparam int HOLD    = 10;
    localparam int BMAX    = 255;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    int m_act [N_CARDS];
    int m_mon [N_CARDS];
    int m_bal [N_CARDS];

    fare_account_if #(.ID_W(3), .BAL_W(8)) bus ();

    fare_account_responder #(
        .N_CARDS(N_CARDS), .ID_W(3), .BAL_W(8), .FARE(FARE), .HOLD_CYCLES(HOLD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < N_CARDS; i++) begin
            m_act[i] = 0;
            m_mon[i] = 0;
            m_bal[i] = 0;
        end
    endtask

    task automatic cfg(input int id, input int act, input int mon, input int b);
        bus.cfg_we      = 1'b1;
        bus.cfg_id      = 3'(id);
        bus.cfg_active  = 1'(act);
        bus.cfg_monthly = 1'(mon);
        bus.cfg_bal     = 8'(b);
        step();
        bus.cfg_we = 1'b0;
        m_act[id] = act;
        m_mon[id] = mon;
        m_bal[id] = b;
    endtask

    task automatic topup(input int id, input int amt);
        bus.topup_valid = 1'b1;
        bus.topup_id    = 3'(id);
        bus.topup_amt   = 8'(amt);
        step();
        bus.topup_valid = 1'b0;
        m_bal[id] = (m_bal[id] + amt > BMAX) ? BMAX : m_bal[id] + amt;
    endtask

    // One tap: k hold cycles before reduce_bal (k >= HOLD means timeout), tp = same-cycle top-up.
    task automatic tap_txn(input int id, input int k, input int tp);
        int ea, ef, em, b0, nb;
        ea = m_act[id];
        em = m_mon[id];
        b0 = m_bal[id];
        ef = (em != 0 || b0 >= FARE) ? 1 : 0;
        bus.nfc     = 1'b1;
        bus.card_id = 3'(id);
        step();
        chk("lookup_busy", int'(bus.busy), 1);
        chk("lookup_rv", int'(bus.resp_valid), 0);
        bus.nfc = 1'b0;
        step();
        chk("hold_rv", int'(bus.resp_valid), 1);
        chk("hold_active", int'(bus.card_active), ea);
        chk("hold_fund", int'(bus.fund_enough), ef);
        chk("hold_monthly", int'(bus.monthly), em);
        chk("hold_bal", int'(bus.balance_out), b0);
        if (k >= HOLD) begin
            for (int c = 1; c < HOLD; c++) begin
                if (c == 3) bus.nfc = 1'b1;
                step();
                chk("hold_wait_rv", int'(bus.resp_valid), 1);
            end
            step();
            chk("timeout_rv", int'(bus.resp_valid), 0);
            chk("timeout_busy", int'(bus.busy), 0);
            chk("timeout_bal", int'(bus.balance_out), b0);
            step();
            step();
            chk("no_retrigger", int'(bus.busy), 0);
            bus.nfc = 1'b0;
            step();
        end else begin
            for (int c = 0; c < k; c++) begin
                step();
                chk("pre_reduce_rv", int'(bus.resp_valid), 1);
            end
            bus.reduce_bal = 1'b1;
            if (tp > 0) begin
                bus.topup_valid = 1'b1;
                bus.topup_id    = 3'(id);
                bus.topup_amt   = 8'(tp);
            end
            step();
            bus.reduce_bal  = 1'b0;
            bus.topup_valid = 1'b0;
            if (ea != 0 && ef != 0) begin
                nb = b0 + tp - ((em != 0) ? 0 : FARE);
                if (nb > BMAX) nb = BMAX;
                chk("debit_bal", int'(bus.balance_out), nb);
                chk("debit_err", int'(bus.err), 0);
                chk("debit_busy", int'(bus.busy), 1);
                chk("debit_rv", int'(bus.resp_valid), 1);
                m_bal[id] = nb;
                step();
                chk("after_debit_busy", int'(bus.busy), 0);
                chk("after_debit_rv", int'(bus.resp_valid), 0);
                chk("after_debit_active", int'(bus.card_active), 0);
                chk("after_debit_bal", int'(bus.balance_out), nb);
            end else begin
                nb = (b0 + tp > BMAX) ? BMAX : b0 + tp;
                chk("reject_err", int'(bus.err), 1);
                chk("reject_busy", int'(bus.busy), 0);
                chk("reject_rv", int'(bus.resp_valid), 0);
                chk("reject_bal", int'(bus.balance_out), b0);
                m_bal[id] = nb;
                step();
                chk("err_one_cycle", int'(bus.err), 0);
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst = 1'b1;
        bus.nfc = 1'b0;  bus.card_id = 3'd0;  bus.reduce_bal = 1'b0;
        bus.cfg_we = 1'b0;  bus.cfg_id = 3'd0;  bus.cfg_active = 1'b0;
        bus.cfg_monthly = 1'b0;  bus.cfg_bal = 8'd0;
        bus.topup_valid = 1'b0;  bus.topup_id = 3'd0;  bus.topup_amt = 8'd0;
        model_clear();
        step();
        step();
        chk("rst_rv", int'(bus.resp_valid), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_err", int'(bus.err), 0);
        chk("rst_bal", int'(bus.balance_out), 0);
        rst = 1'b0;
        step();

        cfg(2, 1, 0, 10);
        tap_txn(2, 1, 0);
        cfg(5, 1, 1, 0);
        tap_txn(5, 0, 0);
        tap_txn(1, 2, 0);
        cfg(2, 1, 0, 2);
        tap_txn(2, 0, 0);
        cfg(2, 1, 0, 10);
        tap_txn(2, HOLD, 0);
        cfg(2, 1, 0, 254);
        topup(2, 5);
        tap_txn(2, 0, 0);
        cfg(2, 1, 0, 10);
        tap_txn(2, 1, 1);
        topup(5, 200);
        topup(5, 200);
        tap_txn(5, 3, 0);

        for (int n = 0; n < 60; n++) begin
            int op, id;
            op = int'($urandom_range(0, 3));
            id = int'($urandom_range(0, N_CARDS - 1));
            if (op == 0) begin
                cfg(id, int'($urandom_range(0, 3)) != 0 ? 1 : 0,
                    int'($urandom_range(0, 3)) == 0 ? 1 : 0,
                    int'($urandom_range(0, 1)) != 0 ? int'($urandom_range(0, 8))
                                                    : int'($urandom_range(0, 255)));
            end else if (op == 1) begin
                topup(id, int'($urandom_range(0, 255)));
            end else begin
                tap_txn(id, int'($urandom_range(0, HOLD + 1)),
                        int'($urandom_range(0, 1)) != 0 ? int'($urandom_range(1, 255)) : 0);
            end
        end

        cfg(2, 1, 1, 77);
        bus.nfc     = 1'b1;
        bus.card_id = 3'd2;
        step();
        bus.nfc = 1'b0;
        step();
        chk("pre_rst_rv", int'(bus.resp_valid), 1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_rv", int'(bus.resp_valid), 0);
        chk("async_rst_busy", int'(bus.busy), 0);
        chk("async_rst_active", int'(bus.card_active), 0);
        chk("async_rst_bal", int'(bus.balance_out), 0);
        step();
        rst = 1'b0;
        model_clear();
        step();
        tap_txn(2, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
